sbus_arbiter: RTL

- Two-to-one arbiter placed after address translation.
- Shares one physical memory bus between the instruction bus and the data bus, both already translated to physical addresses.
- Grants one requester at a time and latches its request for the whole memory transaction.
- Fixed data-bus priority, with a starvation limit that guarantees instruction fetch progress.

---
 rtl/sbus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sbus_arbiter.sv
// sbus_arbiter: two-to-one arbiter sharing one physical memory bus between
// the (already translated) instruction bus and data bus.
//
// The data bus has fixed priority. A starve counter tracks consecutive data
// grants taken while the instruction bus was waiting. Once it reaches
// STARVE_LIMIT, the next contested decision goes to the instruction bus.
// The winner's request is latched for the whole memory transaction.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ibus_*           instruction requester: en/we/size/addr/data_w in,
//                    data_r/stall out
//   dbus_*           data requester: same as ibus_*, plus dbus_uncached in
//   mem_*            memory side: en/we/size/addr/data_w/uncached out,
//                    data_r/stall in. A transfer completes in a cycle with
//                    mem_en=1 and mem_stall=0.
module sbus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ibus_en,
  input  logic              ibus_we,
  input  logic [1:0]        ibus_size,
  input  logic [ADDR_W-1:0] ibus_addr,
  input  logic [DATA_W-1:0] ibus_data_w,
  output logic [DATA_W-1:0] ibus_data_r,
  output logic              ibus_stall,

  input  logic              dbus_en,
  input  logic              dbus_we,
  input  logic [1:0]        dbus_size,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_data_w,
  input  logic              dbus_uncached,
  output logic [DATA_W-1:0] dbus_data_r,
  output logic              dbus_stall,

  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_w,
  output logic              mem_uncached,
  input  logic [DATA_W-1:0] mem_data_r,
  input  logic              mem_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] ibus_rd_q;
  logic [DATA_W-1:0] dbus_rd_q;
  logic              done_i;
  logic              done_d;
  logic              pick_d;

  assign done_i = (state == GNT_I) && !mem_stall;
  assign done_d = (state == GNT_D) && !mem_stall;

  // The data bus wins unless the instruction bus is also waiting and has
  // been passed over STARVE_LIMIT times in a row.
  assign pick_d = dbus_en && (!ibus_en || (starve_cnt != LIMIT));

  assign ibus_stall = ibus_en && !done_i;
  assign dbus_stall = dbus_en && !done_d;

  // Read data is forwarded in the completion cycle and held afterwards.
  assign ibus_data_r = done_i ? mem_data_r : ibus_rd_q;
  assign dbus_data_r = done_d ? mem_data_r : dbus_rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      starve_cnt   <= 4'd0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_size     <= 2'd0;
      mem_addr     <= '0;
      mem_data_w   <= '0;
      mem_uncached <= 1'b0;
      ibus_rd_q    <= '0;
      dbus_rd_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= GNT_D;
            mem_en       <= 1'b1;
            mem_we       <= dbus_we;
            mem_size     <= dbus_size;
            mem_addr     <= dbus_addr;
            mem_data_w   <= dbus_data_w;
            mem_uncached <= dbus_uncached;
            if (!ibus_en)
              starve_cnt <= 4'd0;
            else if (starve_cnt < LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (ibus_en) begin
            state        <= GNT_I;
            mem_en       <= 1'b1;
            mem_we       <= ibus_we;
            mem_size     <= ibus_size;
            mem_addr     <= ibus_addr;
            mem_data_w   <= ibus_data_w;
            mem_uncached <= 1'b0;
            starve_cnt   <= 4'd0;
          end
        end
        GNT_I: begin
          if (!mem_stall) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            ibus_rd_q <= mem_data_r;
          end
        end
        GNT_D: begin
          if (!mem_stall) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            dbus_rd_q <= mem_data_r;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
